// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way request arbiter: FSM state encoding,
// requester count, owner-code width and the index-to-code mapping.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_t;

    // Owner code is the reversed index: req[0] -> 3, req[3] -> 0.
    function automatic logic [ID_W-1:0] idx_to_code(input logic [ID_W-1:0] idx);
        return 2'd3 - idx;
    endfunction

endpackage

// File: rtl/arb_pick4.sv
// Combinational 4-input picker: scans requests starting at index 'base'
// (wrapping mod 4) and reports the first asserted one.
module arb_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    base,
    output logic [NUM_REQ-1:0] winner,
    output logic [ID_W-1:0]    winner_idx,
    output logic               any
);

    // Rotating priority scan; the 2-bit candidate index wraps naturally.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand       = '0;
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = base + ID_W'(k);
            if (!any && req[cand]) begin
                any        = 1'b1;
                winner_idx = cand;
            end
        end
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with IDLE/GRANT/RELEASE FSM and a per-grant hold
// limit. Fixed lowest-index priority by default; defining ARB_RR_EN switches
// to round-robin with a pointer that moves past each granted index.
module req_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    arb_state_t          state, state_nxt;
    logic [ID_W-1:0]     owner, owner_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CNT_W-1:0]    hold_next;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [ID_W-1:0]     gnt_id_nxt;
    logic                gnt_valid_nxt;
    logic                timeout_nxt;

    logic [ID_W-1:0]     base;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;

`ifdef ARB_RR_EN
    logic [ID_W-1:0]     ptr, ptr_nxt;

    // Round-robin pointer: highest priority goes to the index after the last winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr <= '0;
        else          ptr <= ptr_nxt;
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

    arb_pick4 u_pick (
        .req        (req),
        .base       (base),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    assign hold_next = cnt + 1'b1;

    // State, owner, hold counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state and next-output decode; outputs default to the idle/no-owner values.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        cnt_nxt       = cnt;
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
        timeout_nxt   = 1'b0;
`ifdef ARB_RR_EN
        ptr_nxt       = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (ena && pick_any) begin
                    state_nxt     = GRANT;
                    owner_nxt     = pick_idx;
                    cnt_nxt       = '0;
                    gnt_nxt       = pick_onehot;
                    gnt_id_nxt    = idx_to_code(pick_idx);
                    gnt_valid_nxt = 1'b1;
`ifdef ARB_RR_EN
                    ptr_nxt       = pick_idx + 1'b1;
`endif
                end
            end
            GRANT: begin
                cnt_nxt = hold_next;
                // done wins over the hold limit, so a simultaneous limit is not a timeout.
                if (done || !req[owner]) begin
                    state_nxt = RELEASE;
                end else if (hold_next == HOLD_LIM) begin
                    state_nxt   = RELEASE;
                    timeout_nxt = 1'b1;
                end else begin
                    gnt_nxt[owner] = 1'b1;
                    gnt_id_nxt     = idx_to_code(owner);
                    gnt_valid_nxt  = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/req_arbiter4.md
REQ_ARBITER4 -- requirements
Module: req_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum GRANT cycles per grant before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  arbiter enable; low blocks new grants.
REQ-005 req  input  4  request lines, one per requester, level-sensitive.
REQ-006 done  input  1  owner finished; single-cycle pulse, sampled only in GRANT.
REQ-007 gnt  output  4  one-hot grant to the current owner; all-zero when no owner.
REQ-008 gnt_id  output  2  owner code = 3 - owner index (req[0]->11, req[3]->00); the team's encoder code.
REQ-009 gnt_valid  output  1  high while gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 FSM states IDLE, GRANT, RELEASE; all outputs registered.
REQ-012 IDLE: if ena=1 and req!=0 at a posedge, go to GRANT with gnt/gnt_id/gnt_valid set from that edge's winner; latency req->gnt = 1 cycle.
REQ-013 IDLE with ena=0 or req=0: stay; gnt=0, gnt_id=00, gnt_valid=0.
REQ-014 Fixed priority (macro absent): lowest asserted index wins.
REQ-015 GRANT: owner latched; changes on other req bits ignored; no preemption.
REQ-016 GRANT exit to RELEASE on first of: done=1, req[owner]=0, or hold counter reaching MAX_HOLD.
REQ-017 Hold counter cleared on GRANT entry, +1 per GRANT cycle; width clog2(MAX_HOLD+1) bits; never wraps.
REQ-018 Forced release (counter=MAX_HOLD, done=0, req[owner]=1): timeout=1 in the RELEASE cycle only.
REQ-019 done and limit in the same cycle: normal release, timeout stays 0.
REQ-020 RELEASE: exactly one cycle, gnt=0, gnt_valid=0, gnt_id=00; then IDLE unconditionally.
REQ-021 Minimum gap between consecutive grants: 2 cycles (RELEASE + IDLE arbitration edge).
REQ-022 ena falling during GRANT: current grant runs to completion; no new grant until ena=1.
REQ-023 gnt is always one-hot or zero; gnt_valid == |gnt in every cycle.

Reset
REQ-024 reset_n=0 immediately forces IDLE, gnt=0, gnt_id=00, gnt_valid=0, timeout=0, counter=0, RR pointer=0, independent of clk.
REQ-025 Reset mid-GRANT drops the grant without RELEASE cycle or timeout pulse.
REQ-026 After reset_n rises, first arbitration occurs on the first posedge clk with ena=1 and req!=0.

Configuration
REQ-027 Macro ARB_RR_EN defined: round-robin; pointer p (2 bits, reset 0) gives highest priority to index p, then p+1, p+2, p+3 mod 4; on every grant to index i, p becomes (i+1) mod 4.
REQ-028 ARB_RR_EN undefined: fixed priority per REQ-014; no pointer register synthesized.

Structure
REQ-029 Shared package arb_pkg: state enum (IDLE, GRANT, RELEASE), NUM_REQ=4, ID_W=2, index-to-code function (3 - index).
REQ-030 One combinational sub-module arb_pick4: inputs req[3:0], base[1:0]; outputs winner one-hot, winner index, any; fixed mode ties base to 0.

Verification
REQ-031 Fixed: req=1010 at IDLE, ena=1 -> next cycle gnt=0010, gnt_id=10, gnt_valid=1.
REQ-032 Hold limit: MAX_HOLD=4, req=0001 held, done=0 -> gnt=0001 for 4 cycles, then RELEASE with timeout=1, gnt=0, then IDLE regrants 0001.
REQ-033 Done: gnt=0100, done pulse -> next cycle gnt=0, timeout=0; req=0110 remaining -> gnt=0010 two cycles after done.
REQ-034 RR (ARB_RR_EN): req=1111 held, each grant ended by done -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-035 Reset mid-grant: gnt=1000, reset_n=0 between edges -> gnt=0, gnt_valid=0 without a clock edge; after release, req=1000 -> gnt=1000 one cycle later, timeout never pulses.
REQ-036 ena: ena=0, req=1111 -> gnt stays 0; ena=0 during GRANT -> grant holds until done, then no regrant.
